alu_op_decoder: RTL

//  Issue side of the one-hot ALU interface: decodes a 32-bit MIPS instruction into the 12-bit one-hot

---
 rtl/alu_op_decoder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: decodes a MIPS instruction word into one-hot ALU control,
// operand selects and writeback control, behind a registered valid/ready
// stage holding up to two entries (main + skid).
module alu_op_decoder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OP_WIDTH-1:0]   out_alu_op,
  output logic                  out_a_sel,
  output logic [1:0]            out_b_sel,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [4:0]            out_rs,
  output logic [4:0]            out_rt,
  output logic                  out_rf_wen,
  output logic [4:0]            out_rf_waddr,
  output logic                  out_ovf_chk,
  output logic                  out_illegal
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_e;

  typedef enum logic [1:0] {B_RT, B_SEXT, B_ZEXT} bsel_e;

  typedef struct packed {
    logic [OP_WIDTH-1:0]   alu_op;
    logic                  a_sel;
    logic [1:0]            b_sel;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic                  rf_wen;
    logic [4:0]            waddr;
    logic                  ovf_chk;
    logic                  illegal;
  } dec_t;

  logic [5:0] op, funct;
  logic [4:0] rd;
  assign op    = in_inst[31:26];
  assign funct = in_inst[5:0];
  assign rd    = in_inst[15:11];

  alu_e  alu_sel;
  bsel_e b_sel;
  logic  legal, a_sel, wen, to_rd, ovf;
  dec_t  dec;

  // Classify the opcode/funct into ALU operation and control attributes
  always_comb begin
    alu_sel = ALU_ADD;
    legal   = 1'b1;
    a_sel   = 1'b0;
    b_sel   = B_RT;
    wen     = 1'b0;
    to_rd   = 1'b0;
    ovf     = 1'b0;
    case (op)
      6'h00: begin
        wen   = 1'b1;
        to_rd = 1'b1;
        case (funct)
          6'h20: ovf = 1'b1;
          6'h21: alu_sel = ALU_ADD;
          6'h22: begin alu_sel = ALU_SUB; ovf = 1'b1; end
          6'h23: alu_sel = ALU_SUB;
          6'h24: alu_sel = ALU_AND;
          6'h25: alu_sel = ALU_OR;
          6'h26: alu_sel = ALU_XOR;
          6'h27: alu_sel = ALU_NOR;
          6'h2A: alu_sel = ALU_SLT;
          6'h2B: alu_sel = ALU_SLTU;
          6'h00: begin alu_sel = ALU_SLL; a_sel = 1'b1; end
          6'h02: begin alu_sel = ALU_SRL; a_sel = 1'b1; end
          6'h03: begin alu_sel = ALU_SRA; a_sel = 1'b1; end
          6'h04: alu_sel = ALU_SLL;
          6'h06: alu_sel = ALU_SRL;
          6'h07: alu_sel = ALU_SRA;
          default: legal = 1'b0;
        endcase
      end
      6'h08: begin b_sel = B_SEXT; wen = 1'b1; ovf = 1'b1; end
      6'h09: begin b_sel = B_SEXT; wen = 1'b1; end
      6'h0A: begin alu_sel = ALU_SLT;  b_sel = B_SEXT; wen = 1'b1; end
      6'h0B: begin alu_sel = ALU_SLTU; b_sel = B_SEXT; wen = 1'b1; end
      6'h0C: begin alu_sel = ALU_AND;  b_sel = B_ZEXT; wen = 1'b1; end
      6'h0D: begin alu_sel = ALU_OR;   b_sel = B_ZEXT; wen = 1'b1; end
      6'h0E: begin alu_sel = ALU_XOR;  b_sel = B_ZEXT; wen = 1'b1; end
      6'h0F: begin alu_sel = ALU_LUI;  b_sel = B_ZEXT; wen = 1'b1; end
      6'h23: begin b_sel = B_SEXT; wen = 1'b1; end
      6'h2B: b_sel = B_SEXT;
      6'h04: alu_sel = ALU_SUB;
      6'h05: alu_sel = ALU_SUB;
      default: legal = 1'b0;
    endcase
  end

  // Assemble the decoded entry; illegal instructions carry no control
  always_comb begin
    dec    = '0;
    dec.rs = in_inst[25:21];
    dec.rt = in_inst[20:16];
    if (legal) begin
      dec.alu_op[alu_sel] = 1'b1;
      dec.a_sel           = a_sel;
      dec.b_sel           = b_sel;
      case (b_sel)
        B_SEXT:  dec.imm = {{(DATA_WIDTH-16){in_inst[15]}}, in_inst[15:0]};
        B_ZEXT:  dec.imm = {{(DATA_WIDTH-16){1'b0}}, in_inst[15:0]};
        default: dec.imm = '0;
      endcase
      dec.rf_wen  = wen;
      dec.waddr   = wen ? (to_rd ? rd : in_inst[20:16]) : '0;
      dec.ovf_chk = ovf;
    end else begin
      dec.illegal = 1'b1;
    end
  end

  state_e state_q, state_d;
  dec_t   main_q, main_d, skid_q, skid_d;
  logic   in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic   accept, retire;

  // Buffer occupancy control; flush overrides accept and retire
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    accept  = in_valid & in_ready_q;
    retire  = out_valid_q & out_ready;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin state_d = ST_ONE; main_d = dec; end
        ST_ONE: begin
          if (accept && retire) main_d = dec;
          else if (accept) begin state_d = ST_FULL; skid_d = dec; end
          else if (retire) state_d = ST_EMPTY;
        end
        ST_FULL: if (retire) begin state_d = ST_ONE; main_d = skid_q; end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_alu_op   = main_q.alu_op;
  assign out_a_sel    = main_q.a_sel;
  assign out_b_sel    = main_q.b_sel;
  assign out_imm      = main_q.imm;
  assign out_rs       = main_q.rs;
  assign out_rt       = main_q.rt;
  assign out_rf_wen   = main_q.rf_wen;
  assign out_rf_waddr = main_q.waddr;
  assign out_ovf_chk  = main_q.ovf_chk;
  assign out_illegal  = main_q.illegal;

endmodule
